// File: rtl/key_reader_pkg.sv
// rtl/key_reader_pkg.sv - shared states and bus constants for the key sequence reader
package key_reader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RECOVER = 3'd3,
    DONE    = 3'd4
  } key_state_t;

  // Address bits that select the key device during a step
  localparam logic DEV_BA13 = 1'b0;
  localparam logic DEV_BA12 = 1'b1;

  // Address bits parked while idle so the key device is never addressed
  localparam logic IDLE_BA13 = 1'b1;
  localparam logic IDLE_BA12 = 1'b0;

endpackage

// File: rtl/key_strobe_timer.sv
// rtl/key_strobe_timer.sv - down-counter that times the select-low window
module key_strobe_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] len,
  output logic       expired
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Load len-1 so a window of len cycles ends on the cycle the count reads zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = len - 4'd1;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/key_seq_reader.sv
// rtl/key_seq_reader.sv - strobes a serial key device and collects its bits LSB-first
module key_seq_reader
  import key_reader_pkg::*;
#(
  parameter int MAX_BITS   = 32,
  parameter int STROBE_LEN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          step_sel,
  input  logic [5:0]          nbits,
  input  logic                abort,
  input  logic                sdrd,
  output logic                sser_n,
  output logic                ba13,
  output logic                ba12,
  output logic [3:0]          ba_lo,
  output logic                br_w,
  output logic                busy,
  output logic                done,
  output logic [MAX_BITS-1:0] result
);

  localparam logic [5:0] MAX_W = 6'(MAX_BITS);

  key_state_t          state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [5:0]          count_q, count_d;
  logic [5:0]          idx_q, idx_d;
  logic [MAX_BITS-1:0] result_q, result_d;
  logic                tmr_load;
  logic                tmr_expired;

  logic                sser_n_q, sser_n_d;
  logic                ba13_q, ba13_d;
  logic                ba12_q, ba12_d;
  logic [3:0]          ba_lo_q, ba_lo_d;
  logic                br_w_q, br_w_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                active_d;

  key_strobe_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .len     (4'(STROBE_LEN)),
    .expired (tmr_expired)
  );

  // Sequencer: abort wins over every step, and a bit is only written if not aborted
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    count_d  = count_q;
    idx_d    = idx_q;
    result_d = result_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d    = step_sel;
          count_d  = (nbits > MAX_W) ? MAX_W : nbits;
          result_d = '0;
          idx_d    = 6'd0;
          state_d  = (nbits == 6'd0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          tmr_load = 1'b1;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_expired) begin
          for (int i = 0; i < MAX_BITS; i++) begin
            if (idx_q == 6'(i)) result_d[i] = sdrd;
          end
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q < count_q - 6'd1) begin
          idx_d   = idx_q + 6'd1;
          state_d = SETUP;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they leave the block as flops
  always_comb begin
    active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == RECOVER);
    sser_n_d = (state_d != STROBE);
    ba13_d   = active_d ? DEV_BA13 : IDLE_BA13;
    ba12_d   = active_d ? DEV_BA12 : IDLE_BA12;
    ba_lo_d  = active_d ? sel_d : 4'd0;
    br_w_d   = 1'b1;
    busy_d   = active_d;
    done_d   = (state_d == DONE);
  end

  // State, capture and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 4'd0;
      count_q  <= 6'd0;
      idx_q    <= 6'd0;
      result_q <= '0;
      sser_n_q <= 1'b1;
      ba13_q   <= IDLE_BA13;
      ba12_q   <= IDLE_BA12;
      ba_lo_q  <= 4'd0;
      br_w_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      sser_n_q <= sser_n_d;
      ba13_q   <= ba13_d;
      ba12_q   <= ba12_d;
      ba_lo_q  <= ba_lo_d;
      br_w_q   <= br_w_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sser_n = sser_n_q;
  assign ba13   = ba13_q;
  assign ba12   = ba12_q;
  assign ba_lo  = ba_lo_q;
  assign br_w   = br_w_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_key_seq_reader.sv
// tb/tb_key_seq_reader.sv - directed bench for the key sequence reader
module tb_key_seq_reader;

  localparam logic [5:0] SEED = 6'b101101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  step_sel = 4'd0;
  logic [5:0]  nbits = 6'd0;

  logic        s1_sser_n, s1_ba13, s1_ba12, s1_br_w, s1_busy, s1_done, sdrd1;
  logic [3:0]  s1_ba_lo;
  logic [31:0] s1_result;
  logic        s2_sser_n, s2_ba13, s2_ba12, s2_br_w, s2_busy, s2_done, sdrd2;
  logic [3:0]  s2_ba_lo;
  logic [31:0] s2_result;

  int checks = 0;
  int failures = 0;

  key_seq_reader #(.MAX_BITS(32), .STROBE_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .step_sel(step_sel), .nbits(nbits),
    .abort(abort), .sdrd(sdrd1), .sser_n(s1_sser_n), .ba13(s1_ba13), .ba12(s1_ba12),
    .ba_lo(s1_ba_lo), .br_w(s1_br_w), .busy(s1_busy), .done(s1_done), .result(s1_result)
  );

  key_seq_reader #(.MAX_BITS(32), .STROBE_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .step_sel(step_sel), .nbits(nbits),
    .abort(abort), .sdrd(sdrd2), .sser_n(s2_sser_n), .ba13(s2_ba13), .ba12(s2_ba12),
    .ba_lo(s2_ba_lo), .br_w(s2_br_w), .busy(s2_busy), .done(s2_done), .result(s2_result)
  );

  // Key device models: 6-bit LFSR that steps on every selected read cycle
  logic [5:0] m1_q, m2_q;
  always @(posedge clk) begin
    if (rst) m1_q <= SEED;
    else if (!s1_sser_n && !s1_ba13 && s1_ba12 && s1_br_w) m1_q <= {m1_q[4:0], m1_q[5] ^ m1_q[4]};
    if (rst) m2_q <= SEED;
    else if (!s2_sser_n && !s2_ba13 && s2_ba12 && s2_br_w) m2_q <= {m2_q[4:0], m2_q[5] ^ m2_q[4]};
  end
  assign sdrd1 = m1_q[5];
  assign sdrd2 = m2_q[5];

  function automatic logic [31:0] exp_bits(input int len, input int n);
    logic [5:0]  st;
    logic [31:0] r;
    st = SEED;
    r  = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < len - 1; j++) st = {st[4:0], st[5] ^ st[4]};
      r  = r | (32'(st[5]) << i);
      st = {st[4:0], st[5] ^ st[4]};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s1_sser_n !== 1'b1) begin failures++; $display("FAIL reset_sser_n got=%b want=1", s1_sser_n); end
    checks++; if (s1_ba13 !== 1'b1) begin failures++; $display("FAIL reset_ba13 got=%b want=1", s1_ba13); end
    checks++; if (s1_ba12 !== 1'b0) begin failures++; $display("FAIL reset_ba12 got=%b want=0", s1_ba12); end
    checks++; if (s1_ba_lo !== 4'd0) begin failures++; $display("FAIL reset_ba_lo got=%h want=0", s1_ba_lo); end
    checks++; if (s1_br_w !== 1'b1) begin failures++; $display("FAIL reset_br_w got=%b want=1", s1_br_w); end
    checks++; if (s1_busy !== 1'b0 || s1_done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b want=00", s1_busy, s1_done); end
    checks++; if (s1_result !== 32'd0 || s2_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h/%h want=0", s1_result, s2_result); end
  endtask

  task automatic test_basic();
    int busy_n, falls, done_at, done_n;
    logic prev;
    busy_n = 0; falls = 0; done_at = -1; done_n = 0; prev = 1'b1;
    do_reset();
    step_sel = 4'b0010; nbits = 6'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin
        checks++; if ({s1_ba13, s1_ba12, s1_ba_lo, s1_br_w, s1_sser_n} !== 8'b0_1_0010_1_1) begin
          failures++; $display("FAIL basic_setup_bus got=%b want=01001011", {s1_ba13, s1_ba12, s1_ba_lo, s1_br_w, s1_sser_n});
        end
      end
      if (s1_busy) busy_n++;
      if (prev && !s1_sser_n) falls++;
      prev = s1_sser_n;
      if (s1_done) begin done_n++; done_at = c; end
      tick();
    end
    checks++; if (falls != 8) begin failures++; $display("FAIL basic_strobes got=%0d want=8", falls); end
    checks++; if (busy_n != 24) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=24", busy_n); end
    checks++; if (done_at != 25 || done_n != 1) begin failures++; $display("FAIL basic_done got=cycle%0d x%0d want=cycle25 x1", done_at, done_n); end
    checks++; if (s1_result !== exp_bits(1, 8)) begin failures++; $display("FAIL basic_result got=%h want=%h", s1_result, exp_bits(1, 8)); end
    checks++; if (s1_ba13 !== 1'b1 || s1_ba_lo !== 4'd0) begin failures++; $display("FAIL basic_idle_bus got=%b/%h want=1/0", s1_ba13, s1_ba_lo); end
  endtask

  task automatic test_zero_bits();
    int busy_seen, low_seen, done_n;
    logic first_done;
    busy_seen = 0; low_seen = 0; done_n = 0; first_done = 1'b0;
    nbits = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) first_done = s1_done;
      if (s1_busy) busy_seen++;
      if (!s1_sser_n) low_seen++;
      if (s1_done) done_n++;
      tick();
    end
    checks++; if (first_done !== 1'b1 || done_n != 1) begin failures++; $display("FAIL zero_done got=%b x%0d want=1 x1", first_done, done_n); end
    checks++; if (busy_seen != 0 || low_seen != 0) begin failures++; $display("FAIL zero_idle got=busy%0d low%0d want=0 0", busy_seen, low_seen); end
    checks++; if (s1_result !== 32'd0) begin failures++; $display("FAIL zero_result got=%h want=0", s1_result); end
  endtask

  task automatic test_clamp();
    int falls, done_at;
    logic prev;
    falls = 0; done_at = -1; prev = 1'b1;
    do_reset();
    step_sel = 4'b1111; nbits = 6'd63; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      if (prev && !s1_sser_n) falls++;
      prev = s1_sser_n;
      if (s1_done) done_at = c;
      tick();
    end
    checks++; if (falls != 32) begin failures++; $display("FAIL clamp_strobes got=%0d want=32", falls); end
    checks++; if (done_at != 97) begin failures++; $display("FAIL clamp_done got=%0d want=97", done_at); end
    checks++; if (s1_result !== exp_bits(1, 32)) begin failures++; $display("FAIL clamp_result got=%h want=%h", s1_result, exp_bits(1, 32)); end
  endtask

  task automatic test_abort();
    int done_n;
    done_n = 0;
    do_reset();
    step_sel = 4'b0101; nbits = 6'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (s2_done) done_n++;
      if (c == 15) begin
        checks++; if (s2_sser_n !== 1'b0) begin failures++; $display("FAIL abort_in_strobe got=%b want=0", s2_sser_n); end
        abort = 1'b1;
      end
      if (c == 16) begin
        abort = 1'b0;
        checks++; if (s2_sser_n !== 1'b1 || s2_busy !== 1'b0 || s2_ba13 !== 1'b1) begin
          failures++; $display("FAIL abort_release got=%b%b%b want=101", s2_sser_n, s2_busy, s2_ba13);
        end
      end
      tick();
    end
    checks++; if (done_n != 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", done_n); end
    checks++; if (s2_result !== exp_bits(2, 3)) begin failures++; $display("FAIL abort_result got=%h want=%h", s2_result, exp_bits(2, 3)); end
  endtask

  task automatic test_restart_rst();
    int busy_drop, done_n;
    busy_drop = 0; done_n = 0;
    do_reset();
    step_sel = 4'b1001; nbits = 6'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c >= 3 && c <= 6 && !s1_busy) busy_drop++;
      if (s1_done) done_n++;
      if (c == 4) begin
        checks++; if (s1_ba_lo !== 4'b1001) begin failures++; $display("FAIL restart_sel got=%h want=9", s1_ba_lo); end
      end
      if (c == 7) begin
        checks++; if ({s1_sser_n, s1_ba13, s1_ba12, s1_ba_lo, s1_br_w, s1_busy} !== 9'b1_1_0_0000_1_0) begin
          failures++; $display("FAIL rst_outputs got=%b want=110000010", {s1_sser_n, s1_ba13, s1_ba12, s1_ba_lo, s1_br_w, s1_busy});
        end
        checks++; if (s1_result !== 32'd0) begin failures++; $display("FAIL rst_result got=%h want=0", s1_result); end
      end
      if (c == 2) begin start = 1'b1; nbits = 6'd0; end
      if (c == 3) start = 1'b0;
      if (c == 6) rst = 1'b1;
      if (c == 7) rst = 1'b0;
      tick();
    end
    checks++; if (busy_drop != 0) begin failures++; $display("FAIL restart_ignored got=%0d want=0", busy_drop); end
    checks++; if (done_n != 0) begin failures++; $display("FAIL rst_no_done got=%0d want=0", done_n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_bits();
    test_clamp();
    test_abort();
    test_restart_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_seq_reader.md
KEY_SEQ_READER -- requirements
Module: key_seq_reader

Interface
REQ-001 SHALL have parameter MAX_BITS, default 32: width of the result register and the maximum number of bits per run.
REQ-002 SHALL have parameter STROBE_LEN, default 1, range 1..15: number of clock cycles the select is held low for each key step.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a read run; sampled only in IDLE.
REQ-006 SHALL have port step_sel, input, 4 bits: BA7..BA4 pattern driven during each step; captured at start.
REQ-007 SHALL have port nbits, input, 6 bits: number of key bits to collect; captured at start.
REQ-008 SHALL have port abort, input, 1 bit: terminates a run in progress.
REQ-009 SHALL have port sdrd, input, 1 bit: serial key data returned by the key device.
REQ-010 SHALL have port sser_n, output, 1 bit: active-low key-device select.
REQ-011 SHALL have port ba13, output, 1 bit; port ba12, output, 1 bit; port ba_lo, output, 4 bits (BA7..BA4).
REQ-012 SHALL have port br_w, output, 1 bit: 1 = read.
REQ-013 SHALL have port busy, output, 1 bit; port done, output, 1 bit (one-cycle pulse); port result, output, MAX_BITS bits.

Function
REQ-014 SHALL implement the states IDLE, SETUP, STROBE, RECOVER and DONE.
REQ-015 In IDLE, start=1 SHALL capture step_sel and nbits, clear result and the bit index, and go to SETUP; if the captured nbits=0, it SHALL go straight to DONE instead.
REQ-016 A captured nbits greater than MAX_BITS SHALL be clamped to MAX_BITS.
REQ-017 In SETUP (1 cycle), outputs SHALL be ba13=0, ba12=1, ba_lo=step_sel, br_w=1 and sser_n=1.
REQ-018 In STROBE (STROBE_LEN cycles), the address outputs SHALL be unchanged and sser_n=0.
REQ-019 At the clock edge ending the last STROBE cycle, sdrd SHALL be written into result[bit index]; bit 0 is the first bit collected, LSB-first.
REQ-020 In RECOVER (1 cycle), sser_n=1. If the bit index is below count-1, the index SHALL increment and the block goes to SETUP; otherwise it goes to DONE.
REQ-021 Each bit SHALL take exactly STROBE_LEN+2 cycles, so sser_n falls exactly once per bit.
REQ-022 In DONE (1 cycle), done=1 and the block SHALL then return to IDLE; result SHALL hold its value until the next start or rst.
REQ-023 busy SHALL be 1 in SETUP, STROBE and RECOVER, and 0 in IDLE and DONE.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort SHALL take priority over the bit sequence: in the next cycle sser_n=1 and state=IDLE, with no done pulse and result left partially filled.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 If abort coincides with the sampling edge, that bit SHALL NOT be written.
REQ-028 Outside SETUP, STROBE and RECOVER, ba13=1, ba12=0, ba_lo=0 and br_w=1, so the key device is never addressed while idle.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, sser_n=1, ba13=1, ba12=0, ba_lo=0, br_w=1, busy=0, done=0, result=0, bit index=0 and strobe counter=0.
REQ-030 rst SHALL take priority over start and abort.
REQ-031 rst during a run SHALL release the select on the following cycle and SHALL NOT pulse done.

Structure
REQ-032 Package key_reader_pkg SHALL hold the state enum and the constants DEV_BA13=0, DEV_BA12=1, IDLE_BA13=1 and IDLE_BA12=0.
REQ-033 The STROBE_LEN down-counter SHALL be the sub-module key_strobe_timer (inputs load and len; output expired).
REQ-034 All bus outputs SHALL be registered, with no combinational path from any input to sser_n.

Verification
REQ-035 The bench SHALL model the key device as a 6-bit state machine clocked on clk that advances when sser_n=0, ba13=0, ba12=1 and br_w=1, and drives sdrd from its state.
REQ-036 Scenario: STROBE_LEN=1, nbits=8, step_sel=4'b0010 -> 8 sser_n low pulses, 24 busy cycles, done pulse in cycle 25, result[7:0] equal to the model sequence.
REQ-037 Scenario: nbits=0 -> done one cycle after start, busy never 1, sser_n never 0, result=0.
REQ-038 Scenario: nbits=63 with MAX_BITS=32 -> exactly 32 strobes and all 32 result bits written.
REQ-039 Scenario: abort in the 2nd STROBE cycle of bit 3, STROBE_LEN=2 -> sser_n=1 and IDLE next cycle, no done, result[2:0] valid, result[3]=0.
REQ-040 Scenario: start pulsed again while busy, then rst mid-run -> the second start is ignored; after rst all outputs are at reset values and no done pulse appears.
